// File: rtl/adder_sub_module_pkg.sv
// Shared definitions for the registered decimal-range adder:
// default widths, the two-state result FSM and the operand range check.
package adder_pkg;

  localparam int WIDTH       = 12;
  localparam int MAX_OPERAND = 999;

  typedef enum logic {
    IDLE = 1'b0,
    DONE = 1'b1
  } adder_state_t;

  function automatic logic operand_range_check(
    input logic [31:0] value,
    input logic [31:0] max_value
  );
    return (value <= max_value);
  endfunction

endpackage

// File: rtl/adder_sub_module_if.sv
// Operand/result bundle between the operand-entry logic (master) and the adder (slave).
interface adder_sub_module_if #(
  parameter int WIDTH = adder_pkg::WIDTH
);

  logic [WIDTH-1:0] number1;
  logic [WIDTH-1:0] number2;
  logic             enable;
  logic [WIDTH-1:0] sum_result;
  logic             sum_state;

  modport master (
    output number1,
    output number2,
    output enable,
    input  sum_result,
    input  sum_state
  );

  modport slave (
    input  number1,
    input  number2,
    input  enable,
    output sum_result,
    output sum_state
  );

endinterface

// File: rtl/adder_sub_module.sv
// Registered unsigned adder: on each enable edge latches number1+number2 and a
// valid flag, or clears both when an operand is out of range; holds otherwise.
module adder_sub_module #(
  parameter int WIDTH       = adder_pkg::WIDTH,
  parameter int MAX_OPERAND = adder_pkg::MAX_OPERAND
) (
  input  logic              clk,
  input  logic              reset,
  adder_sub_module_if.slave bus
);

  import adder_pkg::*;

  adder_state_t     state_q, state_d;
  logic [WIDTH-1:0] sum_result_q, sum_result_d;
  logic             sum_state_q, sum_state_d;

  logic             sum_carry;
  logic [WIDTH-1:0] sum_trunc;
  logic             operands_ok;

  assign {sum_carry, sum_trunc} = {1'b0, bus.number1} + {1'b0, bus.number2};

  assign operands_ok =
      operand_range_check(32'(bus.number1), 32'(MAX_OPERAND)) &&
      operand_range_check(32'(bus.number2), 32'(MAX_OPERAND));

  // A carry out can only occur if MAX_OPERAND is set too large for WIDTH;
  // such a result is not representable, so it is reported as invalid.
  always_comb begin
    state_d      = state_q;
    sum_result_d = sum_result_q;
    sum_state_d  = sum_state_q;
    if (bus.enable) begin
      if (operands_ok && !sum_carry) begin
        state_d      = DONE;
        sum_result_d = sum_trunc;
        sum_state_d  = 1'b1;
      end else begin
        state_d      = IDLE;
        sum_result_d = '0;
        sum_state_d  = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      sum_result_q <= '0;
      sum_state_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      sum_result_q <= sum_result_d;
      sum_state_q  <= sum_state_d;
    end
  end

  assign bus.sum_result = sum_result_q;
  assign bus.sum_state  = sum_state_q;

endmodule

// File: tb/tb_adder_sub_module.sv
// Directed bench for adder_sub_module: reset, single and repeated adds,
// out-of-range operands, held enable and asynchronous reset.
module tb_adder_sub_module;

  logic clk;
  logic reset;
  int   checks;
  int   errors;

  adder_sub_module_if #(.WIDTH(12)) bus ();

  adder_sub_module #(.WIDTH(12), .MAX_OPERAND(999)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive inputs on the falling edge, then let one rising edge sample them.
  task automatic apply_and_clock(input logic [11:0] n1, input logic [11:0] n2, input logic en);
    @(negedge clk);
    bus.number1 = n1;
    bus.number2 = n2;
    bus.enable  = en;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      apply_and_clock(12'($urandom_range(0, 4095)), 12'($urandom_range(0, 999)), 1'(i % 2 == 0));
      checks++;
      if (bus.sum_result !== 12'd0 || bus.sum_state !== 1'b0) begin
        errors++;
        $display("[TB] FAIL reset_hold cycle %0d: got %0d/%0b expected 0/0", i, bus.sum_result, bus.sum_state);
      end
    end
    @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 2; i++) begin
      apply_and_clock(12'd5, 12'd7, 1'b0);
      checks++;
      if (bus.sum_result !== 12'd0 || bus.sum_state !== 1'b0) begin
        errors++;
        $display("[TB] FAIL reset_idle cycle %0d: got %0d/%0b expected 0/0", i, bus.sum_result, bus.sum_state);
      end
    end
  endtask

  task automatic test_single_add();
    apply_and_clock(12'd897, 12'd78, 1'b1);
    checks++;
    if (bus.sum_result !== 12'd975 || bus.sum_state !== 1'b1) begin
      errors++;
      $display("[TB] FAIL add_897_78: got %0d/%0b expected 975/1", bus.sum_result, bus.sum_state);
    end
    apply_and_clock(12'd10, 12'd20, 1'b0);
    apply_and_clock(12'd500, 12'd400, 1'b0);
    checks++;
    if (bus.sum_result !== 12'd975 || bus.sum_state !== 1'b1) begin
      errors++;
      $display("[TB] FAIL hold_975: got %0d/%0b expected 975/1", bus.sum_result, bus.sum_state);
    end
  endtask

  task automatic test_separate_pulses();
    apply_and_clock(12'd123, 12'd896, 1'b1);
    checks++;
    if (bus.sum_result !== 12'd1019 || bus.sum_state !== 1'b1) begin
      errors++;
      $display("[TB] FAIL add_123_896: got %0d/%0b expected 1019/1", bus.sum_result, bus.sum_state);
    end
    apply_and_clock(12'd1, 12'd1, 1'b0);
    apply_and_clock(12'd999, 12'd999, 1'b1);
    checks++;
    if (bus.sum_result !== 12'd1998 || bus.sum_state !== 1'b1) begin
      errors++;
      $display("[TB] FAIL add_999_999: got %0d/%0b expected 1998/1", bus.sum_result, bus.sum_state);
    end
    apply_and_clock(12'd0, 12'd0, 1'b1);
    checks++;
    if (bus.sum_result !== 12'd0 || bus.sum_state !== 1'b1) begin
      errors++;
      $display("[TB] FAIL add_0_0: got %0d/%0b expected 0/1", bus.sum_result, bus.sum_state);
    end
  endtask

  task automatic test_out_of_range();
    apply_and_clock(12'd1, 12'd1, 1'b1);
    apply_and_clock(12'd1000, 12'd5, 1'b1);
    checks++;
    if (bus.sum_result !== 12'd0 || bus.sum_state !== 1'b0) begin
      errors++;
      $display("[TB] FAIL range_1000_5: got %0d/%0b expected 0/0", bus.sum_result, bus.sum_state);
    end
    apply_and_clock(12'd999, 12'd0, 1'b1);
    checks++;
    if (bus.sum_result !== 12'd999 || bus.sum_state !== 1'b1) begin
      errors++;
      $display("[TB] FAIL range_999_0: got %0d/%0b expected 999/1", bus.sum_result, bus.sum_state);
    end
    apply_and_clock(12'd4095, 12'd1, 1'b1);
    checks++;
    if (bus.sum_result !== 12'd0 || bus.sum_state !== 1'b0) begin
      errors++;
      $display("[TB] FAIL range_4095_1: got %0d/%0b expected 0/0", bus.sum_result, bus.sum_state);
    end
    apply_and_clock(12'd3, 12'd1000, 1'b1);
    checks++;
    if (bus.sum_result !== 12'd0 || bus.sum_state !== 1'b0) begin
      errors++;
      $display("[TB] FAIL range_3_1000: got %0d/%0b expected 0/0", bus.sum_result, bus.sum_state);
    end
  endtask

  task automatic test_back_to_back();
    logic [11:0] a_vec [3];
    logic [11:0] b_vec [3];
    logic [11:0] exp_vec [3];
    a_vec   = '{12'd1, 12'd10, 12'd100};
    b_vec   = '{12'd2, 12'd20, 12'd200};
    exp_vec = '{12'd3, 12'd30, 12'd300};
    for (int i = 0; i < 3; i++) begin
      apply_and_clock(a_vec[i], b_vec[i], 1'b1);
      checks++;
      if (bus.sum_result !== exp_vec[i] || bus.sum_state !== 1'b1) begin
        errors++;
        $display("[TB] FAIL back_to_back %0d: got %0d/%0b expected %0d/1", i, bus.sum_result, bus.sum_state, exp_vec[i]);
      end
    end
  endtask

  task automatic test_async_reset();
    apply_and_clock(12'd897, 12'd78, 1'b1);
    checks++;
    if (bus.sum_result !== 12'd975 || bus.sum_state !== 1'b1) begin
      errors++;
      $display("[TB] FAIL pre_async_975: got %0d/%0b expected 975/1", bus.sum_result, bus.sum_state);
    end
    bus.enable = 1'b0;
    #1;
    reset = 1'b0;
    #1;
    checks++;
    if (bus.sum_result !== 12'd0 || bus.sum_state !== 1'b0) begin
      errors++;
      $display("[TB] FAIL async_clear: got %0d/%0b expected 0/0", bus.sum_result, bus.sum_state);
    end
    @(negedge clk);
    reset = 1'b1;
    apply_and_clock(12'd4, 12'd5, 1'b0);
    checks++;
    if (bus.sum_result !== 12'd0 || bus.sum_state !== 1'b0) begin
      errors++;
      $display("[TB] FAIL post_async_idle: got %0d/%0b expected 0/0", bus.sum_result, bus.sum_state);
    end
    apply_and_clock(12'd4, 12'd5, 1'b1);
    checks++;
    if (bus.sum_result !== 12'd9 || bus.sum_state !== 1'b1) begin
      errors++;
      $display("[TB] FAIL post_async_add: got %0d/%0b expected 9/1", bus.sum_result, bus.sum_state);
    end
  endtask

  initial begin
    checks      = 0;
    errors      = 0;
    reset       = 1'b0;
    bus.number1 = '0;
    bus.number2 = '0;
    bus.enable  = 1'b0;
    test_reset();
    test_single_add();
    test_separate_pulses();
    test_out_of_range();
    test_back_to_back();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
